// File: rtl/mult32_seq_ctrl.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH-edge fixed latency.
// Optional macro MULT_SEQ_ABORT_EN adds an abort input that cancels an operation in CALC.
module mult32_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef MULT_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic               abort_s;

`ifdef MULT_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // One iteration: conditional add into the upper half, then shift {carry, acc} right.
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    acc_d = acc_q;
    if (acc_q[0]) begin
      sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end else begin
      sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end

  // Control FSM with registered busy/done/product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          if (abort_s) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            // Completion wins over a start sampled this edge: start while busy is ignored.
            if (cnt_q == LAST_CNT) begin
              product_q <= acc_d;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              busy_q    <= 1'b1;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed bench for mult32_seq_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_mult32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
`ifdef MULT_SEQ_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_prod;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] vp;
  } vec_t;

  vec_t vecs[10];

  mult32_seq_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef MULT_SEQ_ABORT_EN
    .abort  (abort),
`endif
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 40 edges for done; returns edges taken and whether product moved meanwhile.
  task automatic wait_done(output int n, output bit moved);
    n = 0;
    moved = 1'b0;
    while (n < 40) begin
      step();
      n++;
      if (done) break;
      if (product !== exp_prod) moved = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic [63:0] vp);
    int n;
    bit moved;
    start = 1'b1; a = va; b = vb;
    step();
    start = 1'b0; a = ~va; b = ~vb;
    chk({name, " busy@T0"}, {63'd0, busy}, 64'd1);
    wait_done(n, moved);
    chk({name, " latency"}, 64'(n), 64'd32);
    chk({name, " product hold"}, {63'd0, moved}, 64'd0);
    chk({name, " product"}, product, vp);
    chk({name, " busy@done"}, {63'd0, busy}, 64'd0);
    exp_prod = vp;
    step();
    chk({name, " done cleared"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    bit moved;
    int dcount;

    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
    vecs[2] = '{32'd0,          32'h12345678,   64'd0};
    vecs[3] = '{32'h80000000,   32'd2,          64'h1_00000000};
    vecs[4] = '{32'd1,          32'hFFFFFFFF,   64'h0_FFFFFFFF};
    vecs[5] = '{32'hFFFFFFFF,   32'd1,          64'h0_FFFFFFFF};
    vecs[6] = '{32'h00010000,   32'h00010000,   64'h1_00000000};
    vecs[7] = '{32'hFFFFFFFF,   32'd2,          64'h1_FFFFFFFE};
    vecs[8] = '{32'h0000FFFF,   32'h0000FFFF,   64'h0_FFFE0001};
    vecs[9] = '{32'd100,        32'd100,        64'd10000};

    rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
`ifdef MULT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    exp_prod = 64'd0;
    step(); step();
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset product", product, 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vp);
    end

    // start while busy is ignored, then back-to-back accept in the done cycle
    start = 1'b1; a = 32'd7; b = 32'd6;
    step();
    start = 1'b0;
    repeat (9) step();
    start = 1'b1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    chk("ignore busy", {63'd0, busy}, 64'd1);
    wait_done(n, moved);
    chk("ignore latency", 64'(n), 64'd22);
    chk("ignore product", product, 64'd42);
    exp_prod = 64'd42;
    start = 1'b1; a = 32'd2; b = 32'd21;
    step();
    start = 1'b0;
    chk("b2b busy", {63'd0, busy}, 64'd1);
    chk("b2b done low", {63'd0, done}, 64'd0);
    chk("b2b product held", product, 64'd42);
    wait_done(n, moved);
    chk("b2b latency", 64'(n), 64'd32);
    chk("b2b hold", {63'd0, moved}, 64'd0);
    chk("b2b product", product, 64'd42);
    step();

    // asynchronous reset mid-operation
    start = 1'b1; a = 32'd100; b = 32'd100;
    step();
    start = 1'b0;
    repeat (14) step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst busy", {63'd0, busy}, 64'd0);
    chk("arst done", {63'd0, done}, 64'd0);
    chk("arst product", product, 64'd0);
    #7;
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) dcount++;
    end
    chk("arst no done", 64'(dcount), 64'd0);
    exp_prod = 64'd0;
    run_op("after arst", 32'd100, 32'd100, 64'd10000);

`ifdef MULT_SEQ_ABORT_EN
    // abort at T0+20 keeps previous product
    start = 1'b1; a = 32'd5; b = 32'd5;
    step();
    start = 1'b0;
    repeat (19) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    chk("abort product", product, 64'd10000);
    // abort on the final iteration edge suppresses completion
    start = 1'b1; a = 32'd6; b = 32'd6;
    step();
    start = 1'b0;
    repeat (31) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    dcount = 0;
    if (done) dcount++;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done) dcount++;
    end
    chk("abort last no done", 64'(dcount), 64'd0);
    chk("abort last busy", {63'd0, busy}, 64'd0);
    chk("abort last product", product, 64'd10000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
